hazard_stall_ctrl: RTL

- ID-stage pipeline controller for the 5-stage MIPS CPU.
- Decodes the IF/ID instruction to configure the immediate extender: zero-extend for andi/ori/xori, sign-extend otherwise.
- Detects load-use hazards and sequences multi-cycle stalls.
- Flushes the pipeline on a taken branch resolved in MEM, and keeps saturating stall/flush performance counters.

---
 rtl/hazard_stall_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - opcode and FSM state encodings for the ID-stage hazard/stall controller
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1
    } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - saturating event counter, holds at all-ones
module hazard_stall_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage load-use stall sequencer, branch flush and extender select
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             ext_sign_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] REM_INIT = 2'(LOAD_STALL_CYC - 1);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hazard;
    logic       stall_active;
    logic       flush_inc;
    logic       unused_imm;

    state_e     state_q, state_d;
    logic [1:0] rem_q, rem_d;

    assign op         = instr_i[31:26];
    assign rs         = instr_i[25:21];
    assign rt         = instr_i[20:16];
    assign unused_imm = ^instr_i[15:0];

    assign ext_sign_o = !((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI));
    assign uses_rt    = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    assign hazard     = idex_memread_i && (idex_rt_i != 5'd0) &&
                        ((idex_rt_i == rs) || (uses_rt && (idex_rt_i == rt)));

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        stall_active  = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;

        // The branch squashes whatever is stalled, so it overrides any hazard.
        if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            state_d       = ST_RUN;
            rem_d         = 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        stall_active = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            state_d = ST_STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    stall_active = 1'b1;
                    rem_d        = rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end

        if (stall_active) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end

        // Inputs may still look hazardous while held in reset; keep the pipe flowing.
        if (!rst_i) begin
            stall_active  = 1'b0;
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b0;
            idex_flush_o  = 1'b0;
            exmem_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign state_o   = state_q;
    assign flush_inc = branch_taken_i && rst_i;

    hazard_stall_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .inc_i  (stall_active),
        .cnt_o  (stall_cnt_o)
    );

    hazard_stall_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .inc_i  (flush_inc),
        .cnt_o  (flush_cnt_o)
    );

endmodule
